// File: rtl/battleship_pkg.sv
// Shared types and constants for the battleship PC attacker.
package battleship_pkg;

  localparam int unsigned BoardN = 5;

  typedef logic [2:0] coord_t;

  typedef enum logic [2:0] {
    StIdle,
    StThink,
    StPick,
    StOffer,
    StWaitRes
  } state_e;

  // Fibonacci taps 8,6,5,4 mapped onto bits 7,5,4,3
  localparam logic [7:0] LfsrTaps = 8'b1011_1000;

  function automatic logic lfsr_feedback(logic [7:0] q);
    return ^(q & LfsrTaps);
  endfunction

endpackage

// File: rtl/battleship_lfsr8.sv
// Free-running 8-bit Fibonacci LFSR with synchronous seed load.
module battleship_lfsr8
  import battleship_pkg::*;
#(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk_i,
  input  logic       load_i,
  output logic [7:0] q_o
);

  logic [7:0] q_q;

  always_ff @(posedge clk_i) begin
    if (load_i) begin
      q_q <= SEED;
    end else begin
      q_q <= {q_q[6:0], lfsr_feedback(q_q)};
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/battleship_pc_attacker.sv
// Computer opponent: picks a free cell of the player's board, hunting around the last hit.
module battleship_pc_attacker
  import battleship_pkg::*;
#(
  parameter int unsigned BOARD_N      = BoardN,
  parameter int unsigned THINK_CYCLES = 16,
  parameter logic [7:0]  LFSR_SEED    = 8'hA5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       new_game,
  input  logic       turn_req,
  output logic       atk_valid,
  output logic [2:0] atk_x,
  output logic [2:0] atk_y,
  input  logic       atk_ack,
  input  logic       res_valid,
  input  logic       res_hit,
  output logic       busy,
  output logic       board_full,
  output logic [4:0] shots_count
);

  localparam int unsigned Cells = BOARD_N * BOARD_N;
  localparam int unsigned IdxW  = 5;
  localparam int unsigned CntW  = $clog2(THINK_CYCLES + 1);
  localparam coord_t      MaxC  = coord_t'(BOARD_N - 1);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(Cells - 1);
  localparam logic [IdxW-1:0] CellsW  = IdxW'(Cells);

  function automatic logic [IdxW-1:0] idx_of(coord_t x, coord_t y);
    return IdxW'(y * BOARD_N + x);
  endfunction

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q;
  logic [IdxW-1:0]   cand_q;
  logic [Cells-1:0]  shot_q;
  logic [4:0]        shots_q;
  logic              full_q;
  logic              hunt_q;
  coord_t            hx_q, hy_q;
  logic [1:0]        dir_q;
  coord_t            atk_x_q, atk_y_q;

  logic              clear;
  logic [7:0]        lfsr;
  logic [IdxW-1:0]   rand_r, rand_idx;
  logic              nb_ok, nb_free;
  coord_t            nb_x, nb_y;
  logic              pick_found;
  coord_t            pick_x, pick_y;

  assign clear = reset | new_game;

  battleship_lfsr8 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk_i  (clk),
    .load_i (clear),
    .q_o    (lfsr)
  );

  always_comb begin
    rand_r   = lfsr[4:0];
    rand_idx = (rand_r >= CellsW) ? rand_r - CellsW : rand_r;
  end

  // Hunt neighbour under test: 0 up, 1 right, 2 down, 3 left
  always_comb begin
    nb_ok = 1'b0;
    nb_x  = hx_q;
    nb_y  = hy_q;
    unique case (dir_q)
      2'd0:    begin nb_ok = (hy_q != '0);   nb_y = hy_q - 3'd1; end
      2'd1:    begin nb_ok = (hx_q != MaxC); nb_x = hx_q + 3'd1; end
      2'd2:    begin nb_ok = (hy_q != MaxC); nb_y = hy_q + 3'd1; end
      default: begin nb_ok = (hx_q != '0);   nb_x = hx_q - 3'd1; end
    endcase
    nb_free = nb_ok && !shot_q[idx_of(nb_x, nb_y)];
  end

  always_comb begin
    if (hunt_q) begin
      pick_found = nb_free;
      pick_x     = nb_x;
      pick_y     = nb_y;
    end else begin
      pick_found = !shot_q[cand_q];
      pick_x     = coord_t'(cand_q % IdxW'(BOARD_N));
      pick_y     = coord_t'(cand_q / IdxW'(BOARD_N));
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (turn_req && !full_q) state_d = StThink;
      StThink:   if (cnt_q == '0)         state_d = StPick;
      StPick:    if (pick_found)          state_d = StOffer;
      StOffer:   if (atk_ack)             state_d = StWaitRes;
      StWaitRes: if (res_valid)           state_d = StIdle;
      default:                            state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      cnt_q   <= '0;
      cand_q  <= '0;
      shot_q  <= '0;
      shots_q <= '0;
      full_q  <= 1'b0;
      hunt_q  <= 1'b0;
      hx_q    <= '0;
      hy_q    <= '0;
      dir_q   <= '0;
      atk_x_q <= '0;
      atk_y_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (turn_req && !full_q) cnt_q <= CntW'(THINK_CYCLES - 1);
        end
        StThink: begin
          if (cnt_q == '0) begin
            cand_q <= rand_idx;
            dir_q  <= '0;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StPick: begin
          if (pick_found) begin
            atk_x_q <= pick_x;
            atk_y_q <= pick_y;
          end else if (hunt_q) begin
            // All four neighbours exhausted: fall back to the random candidate
            if (dir_q == 2'd3) hunt_q <= 1'b0;
            else               dir_q  <= dir_q + 2'd1;
          end else begin
            cand_q <= (cand_q == LastIdx) ? '0 : cand_q + 1'b1;
          end
        end
        StOffer: begin
          if (atk_ack) begin
            shot_q[idx_of(atk_x_q, atk_y_q)] <= 1'b1;
            shots_q <= shots_q + 5'd1;
            full_q  <= (shots_q == 5'(Cells - 1));
          end
        end
        StWaitRes: begin
          if (res_valid && res_hit) begin
            hunt_q <= 1'b1;
            hx_q   <= atk_x_q;
            hy_q   <= atk_y_q;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    atk_valid   = (state_q == StOffer);
    busy        = (state_q != StIdle);
    atk_x       = atk_x_q;
    atk_y       = atk_y_q;
    board_full  = full_q;
    shots_count = shots_q;
  end

endmodule

// File: tb/tb_battleship_pc_attacker.sv
// Directed self-checking bench for battleship_pc_attacker (THINK_CYCLES = 4).
module tb_battleship_pc_attacker;

  logic       clk = 1'b0;
  logic       reset, new_game, turn_req, atk_ack, res_valid, res_hit;
  logic       atk_valid, busy, board_full;
  logic [2:0] atk_x, atk_y;
  logic [4:0] shots_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  battleship_pc_attacker #(
    .BOARD_N      (5),
    .THINK_CYCLES (4),
    .LFSR_SEED    (8'hA5)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .new_game    (new_game),
    .turn_req    (turn_req),
    .atk_valid   (atk_valid),
    .atk_x       (atk_x),
    .atk_y       (atk_y),
    .atk_ack     (atk_ack),
    .res_valid   (res_valid),
    .res_hit     (res_hit),
    .busy        (busy),
    .board_full  (board_full),
    .shots_count (shots_count)
  );

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_new_game();
    new_game = 1'b1;
    tick();
    new_game = 1'b0;
  endtask

  // Issue a turn and wait (bounded) for the offer; lat counts edges after the request edge
  task automatic request_offer(output int x, output int y, output int lat);
    turn_req = 1'b1;
    tick();
    turn_req = 1'b0;
    lat = 1;
    while (!atk_valid && lat < 200) begin
      tick();
      lat++;
    end
    check_eq("offer_seen", int'(atk_valid), 1);
    x = int'(atk_x);
    y = int'(atk_y);
  endtask

  task automatic finish_turn(input logic hit);
    atk_ack = 1'b1;
    tick();
    atk_ack   = 1'b0;
    res_valid = 1'b1;
    res_hit   = hit;
    tick();
    res_valid = 1'b0;
    res_hit   = 1'b0;
  endtask

  task automatic expect_offer(input string tag, input int ex, input int ey);
    int x, y, lat;
    request_offer(x, y, lat);
    check_eq({tag, "_x"}, x, ex);
    check_eq({tag, "_y"}, y, ey);
  endtask

  task automatic start_after(input int k);
    pulse_new_game();
    repeat (k) tick();
  endtask

  initial begin
    int x, y, lat, x0, y0, bad, idx, dups, active;
    int k12, k0;
    bit seen [25];
    int hunt_x [4] = '{2, 3, 2, 1};
    int hunt_y [4] = '{1, 2, 3, 2};

    reset = 1'b1; new_game = 1'b0; turn_req = 1'b0;
    atk_ack = 1'b0; res_valid = 1'b0; res_hit = 1'b0;
    repeat (3) tick();
    reset = 1'b0;

    check_eq("rst_valid", int'(atk_valid), 0);
    check_eq("rst_busy", int'(busy), 0);
    check_eq("rst_shots", int'(shots_count), 0);
    check_eq("rst_full", int'(board_full), 0);
    check_eq("rst_x", int'(atk_x), 0);
    check_eq("rst_y", int'(atk_y), 0);

    // Timing: first offer no earlier than THINK_CYCLES+1 edges
    turn_req = 1'b1;
    tick();
    turn_req = 1'b0;
    check_eq("busy_cycle1", int'(busy), 1);
    lat = 1;
    while (!atk_valid && lat < 200) begin
      tick();
      lat++;
    end
    check_eq("offer_seen", int'(atk_valid), 1);
    check_eq("latency_min", int'(lat >= 5), 1);
    check_eq("first_x_range", int'(atk_x <= 3'd4), 1);
    check_eq("first_y_range", int'(atk_y <= 3'd4), 1);

    // Ack hold
    x0 = int'(atk_x);
    y0 = int'(atk_y);
    bad = 0;
    repeat (100) begin
      tick();
      if (!atk_valid || int'(atk_x) != x0 || int'(atk_y) != y0) bad++;
    end
    check_eq("hold_unstable_cycles", bad, 0);
    atk_ack = 1'b1;
    tick();
    atk_ack = 1'b0;
    check_eq("ack_valid_drop", int'(atk_valid), 0);
    check_eq("ack_shots", int'(shots_count), 1);
    check_eq("ack_busy_wait", int'(busy), 1);
    res_valid = 1'b1;
    tick();
    res_valid = 1'b0;
    check_eq("res_idle", int'(busy), 0);

    // Find start delays whose first random pick lands on (2,2) and (0,0)
    k12 = -1;
    k0  = -1;
    for (int k = 0; k < 300 && (k12 < 0 || k0 < 0); k++) begin
      start_after(k);
      request_offer(x, y, lat);
      if (y * 5 + x == 12 && k12 < 0) k12 = k;
      if (x == 0 && y == 0 && k0 < 0) k0 = k;
    end
    check_eq("found_center_delay", int'(k12 >= 0), 1);
    check_eq("found_corner_delay", int'(k0 >= 0), 1);

    // Hunt around the centre
    if (k12 >= 0) begin
      start_after(k12);
      expect_offer("center_seed", 2, 2);
      finish_turn(1'b1);
      for (int i = 0; i < 4; i++) begin
        expect_offer($sformatf("hunt%0d", i), hunt_x[i], hunt_y[i]);
        finish_turn(1'b0);
      end
      request_offer(x, y, lat);
      idx = y * 5 + x;
      check_eq("center_fallback_fresh",
               int'(x < 5 && y < 5 && idx != 12 && idx != 7 && idx != 13 && idx != 17
                    && idx != 11), 1);
      finish_turn(1'b0);
      check_eq("center_shots", int'(shots_count), 6);
    end

    // Hunt from the corner
    if (k0 >= 0) begin
      start_after(k0);
      expect_offer("corner_seed", 0, 0);
      finish_turn(1'b1);
      expect_offer("corner_right", 1, 0);
      finish_turn(1'b0);
      expect_offer("corner_down", 0, 1);
      finish_turn(1'b0);
      request_offer(x, y, lat);
      idx = y * 5 + x;
      check_eq("corner_fallback_fresh",
               int'(x < 5 && y < 5 && idx != 0 && idx != 1 && idx != 5), 1);
      finish_turn(1'b0);
    end

    // Exhaustion
    pulse_new_game();
    dups = 0;
    foreach (seen[i]) seen[i] = 1'b0;
    for (int t = 0; t < 25; t++) begin
      request_offer(x, y, lat);
      check_eq("exh_range", int'(x < 5 && y < 5), 1);
      idx = y * 5 + x;
      if (x < 5 && y < 5) begin
        if (seen[idx]) dups++;
        seen[idx] = 1'b1;
      end
      finish_turn(1'b0);
    end
    check_eq("exh_duplicates", dups, 0);
    check_eq("exh_shots", int'(shots_count), 25);
    check_eq("exh_full", int'(board_full), 1);
    turn_req = 1'b1;
    tick();
    turn_req = 1'b0;
    active = 0;
    repeat (10) begin
      if (busy || atk_valid) active++;
      tick();
    end
    check_eq("exh_26th_ignored", active, 0);

    // Abort with reset during OFFER
    pulse_new_game();
    check_eq("ng_clears_full", int'(board_full), 0);
    request_offer(x, y, lat);
    finish_turn(1'b0);
    check_eq("abort_pre_shots", int'(shots_count), 1);
    request_offer(x, y, lat);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("rst_abort_valid", int'(atk_valid), 0);
    check_eq("rst_abort_shots", int'(shots_count), 0);
    check_eq("rst_abort_busy", int'(busy), 0);

    // Abort with new_game during OFFER
    request_offer(x, y, lat);
    finish_turn(1'b0);
    request_offer(x, y, lat);
    pulse_new_game();
    check_eq("ng_abort_valid", int'(atk_valid), 0);
    check_eq("ng_abort_shots", int'(shots_count), 0);
    check_eq("ng_abort_busy", int'(busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
